// File: rtl/sd_pkg.sv
// Shared sigma-delta definitions: PCM width default, CIC order and the
// derived internal width / output scaling used by the demodulator.
package sd_pkg;

   localparam int unsigned SD_DATA_WIDTH  = 16;
   localparam int unsigned SD_LOG2_DECIM  = 6;
   localparam int unsigned CIC_ORDER      = 3;
   // Decimated outputs discarded after reset/clear while the comb delays fill
   localparam int unsigned WARMUP_FRAMES  = CIC_ORDER - 1;

   typedef logic [SD_DATA_WIDTH-1:0] pcm_t;

   // Internal CIC register width: order*log2(R) bit growth plus sign and +R^N headroom
   function automatic int unsigned cic_width(input int unsigned log2_decim);
      return CIC_ORDER * log2_decim + 2;
   endfunction

   // Arithmetic right shift that maps the +/-R^N comb range onto the PCM word
   function automatic int unsigned cic_shift(input int unsigned log2_decim,
                                             input int unsigned data_width);
      return CIC_ORDER * log2_decim - data_width + 1;
   endfunction

endpackage

// File: rtl/cic_integrator.sv
// Enabled W-bit accumulator for one CIC integrator stage; wraps modulo 2^W.
module cic_integrator #(
   parameter int unsigned W = 20
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] acc
);

   // Accumulate on each accepted sample; clear has priority over the enable
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + din;
      end
   end

endmodule

// File: rtl/sigma_delta_demod.sv
// 1-bit PDM/sigma-delta demodulator: 3rd-order CIC decimator by 2^LOG2_DECIM
// with output scaling, saturation and a warm-up blanking period.
module sigma_delta_demod
   import sd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = SD_DATA_WIDTH,
   parameter int unsigned LOG2_DECIM   = SD_LOG2_DECIM,
   parameter bit          UNSIGNED_OUT = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clear,
   input  logic                  sample_en,
   input  logic                  bit_in,
   output logic [DATA_WIDTH-1:0] pcm_data,
   output logic                  pcm_valid
);

   localparam int unsigned W     = cic_width(LOG2_DECIM);
   localparam int unsigned SHIFT = cic_shift(LOG2_DECIM, DATA_WIDTH);
   localparam logic [1:0]  WARM_LAST = 2'(WARMUP_FRAMES);
   localparam logic signed [W-1:0] PCM_MAX =
      {{(W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [W-1:0] PCM_MIN =
      {{(W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic [W-1:0]            x;
   logic [W-1:0]            i1, i2, i3;
   logic [W-1:0]            d1, d2, d3;
   logic [W-1:0]            c1, c2, c3;
   logic signed [W-1:0]     scaled;
   logic [DATA_WIDTH-1:0]   sat;
   logic [DATA_WIDTH-1:0]   pcm_next;
   logic [LOG2_DECIM-1:0]   cnt;
   logic                    dec_stb;
   logic [1:0]              warm_cnt;

   // Map the bit to +1 / -1 at full internal width
   always_comb begin
      x = bit_in ? W'(1) : '1;
   end

   // Each stage adds the previous stage's pre-edge value: pipelined integrators
   cic_integrator #(.W(W)) u_int1 (
      .clk(clk), .resetn(resetn), .clear(clear), .en(sample_en), .din(x),  .acc(i1)
   );
   cic_integrator #(.W(W)) u_int2 (
      .clk(clk), .resetn(resetn), .clear(clear), .en(sample_en), .din(i1), .acc(i2)
   );
   cic_integrator #(.W(W)) u_int3 (
      .clk(clk), .resetn(resetn), .clear(clear), .en(sample_en), .din(i2), .acc(i3)
   );

   // Decimation counter; strobe registered on the edge accepting the R-th bit
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         cnt     <= '0;
         dec_stb <= 1'b0;
      end else begin
         dec_stb <= sample_en && (cnt == '1);
         if (sample_en) begin
            cnt <= cnt + LOG2_DECIM'(1);
         end
      end
   end

   // Comb chain, scaling, saturation and output coding
   always_comb begin
      c1     = i3 - d1;
      c2     = c1 - d2;
      c3     = c2 - d3;
      scaled = $signed(c3) >>> SHIFT;
      if (scaled > PCM_MAX) begin
         sat = PCM_MAX[DATA_WIDTH-1:0];
      end else if (scaled < PCM_MIN) begin
         sat = PCM_MIN[DATA_WIDTH-1:0];
      end else begin
         sat = scaled[DATA_WIDTH-1:0];
      end
      pcm_next = sat;
      if (UNSIGNED_OUT) begin
         pcm_next[DATA_WIDTH-1] = ~sat[DATA_WIDTH-1];
      end
   end

   // Comb delays advance on every decimated frame; output only after warm-up
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         d1        <= '0;
         d2        <= '0;
         d3        <= '0;
         warm_cnt  <= '0;
         pcm_data  <= '0;
         pcm_valid <= 1'b0;
      end else begin
         pcm_valid <= 1'b0;
         if (dec_stb) begin
            d1 <= i3;
            d2 <= c1;
            d3 <= c2;
            if (warm_cnt == WARM_LAST) begin
               pcm_data  <= pcm_next;
               pcm_valid <= 1'b1;
            end else begin
               warm_cnt <= warm_cnt + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sigma_delta_demod.sv
// Self-checking bench for sigma_delta_demod: unsigned and signed instances
// share stimulus; a convolution-form CIC reference predicts every output.
module tb_sigma_delta_demod;

   localparam int R     = 64;
   localparam int SHIFT = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        clear = 1'b0;
   logic        sample_en = 1'b0;
   logic        bit_in = 1'b0;
   logic [15:0] pcm_u, pcm_s;
   logic        val_u, val_s;

   always #5 clk = ~clk;

   sigma_delta_demod #(.DATA_WIDTH(16), .LOG2_DECIM(6), .UNSIGNED_OUT(1'b1)) dut_u (
      .clk(clk), .resetn(resetn), .clear(clear), .sample_en(sample_en),
      .bit_in(bit_in), .pcm_data(pcm_u), .pcm_valid(val_u)
   );

   sigma_delta_demod #(.DATA_WIDTH(16), .LOG2_DECIM(6), .UNSIGNED_OUT(1'b0)) dut_s (
      .clk(clk), .resetn(resetn), .clear(clear), .sample_en(sample_en),
      .bit_in(bit_in), .pcm_data(pcm_s), .pcm_valid(val_s)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit checking = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   typedef struct {
      int          cyc;
      logic [15:0] u;
      logic [15:0] s;
   } exp_t;

   int          xs[$];     // accepted inputs (+1/-1) since last reset/clear
   longint      fh[$];     // I3 value at each frame boundary, fh[0] = 0
   int          frames;
   exp_t        expq[$];
   logic [15:0] hold_u = '0, hold_s = '0;
   logic [15:0] cap_u[$], cap_s[$];

   // Triple running sum of the inputs, written as a weighted sum: x[j]*C(n-1-j,2)
   function automatic longint i3_after(input int n);
      longint acc;
      longint t;
      acc = 0;
      for (int j = 0; j < n; j++) begin
         t = longint'(n - 1 - j);
         acc += longint'(xs[j]) * ((t * (t - 1)) / 2);
      end
      return acc;
   endfunction

   function automatic longint getf(input int m);
      return (m < 0) ? 64'sd0 : fh[m];
   endfunction

   function automatic void scale(input longint v, output logic [15:0] u, output logic [15:0] s);
      longint q;
      q = v >>> SHIFT;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      s = q[15:0];
      u = s ^ 16'h8000;
   endfunction

   task automatic model_clear();
      xs.delete();
      fh.delete();
      fh.push_back(0);
      frames = 0;
      expq.delete();
      hold_u = '0;
      hold_s = '0;
   endtask

   task automatic model_accept(input logic b);
      longint      o;
      logic [15:0] u, s;
      exp_t        e;
      xs.push_back(b ? 1 : -1);
      if (xs.size() % R == 0) begin
         frames++;
         fh.push_back(i3_after(xs.size()));
         o = getf(frames) - 3 * getf(frames - 1) + 3 * getf(frames - 2) - getf(frames - 3);
         if (frames > 2) begin
            scale(o, u, s);
            e.cyc = cyc + 1;
            e.u = u;
            e.s = s;
            expq.push_back(e);
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_range(input string name, input logic [15:0] act, input logic [15:0] exp, input int tol);
      int d;
      vectors++;
      d = int'(act) - int'(exp);
      if (d < 0) d = -d;
      if (d > tol) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h +/- %0d", name, act, exp, tol);
      end
   endtask

   // Monitor: valid pulses must land exactly on predicted cycles; data held otherwise
   exp_t mon_e;
   bit   exp_v;
   always @(negedge clk) begin
      if (checking) begin
         while (expq.size() > 0 && expq[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_valid: got none, expected pulse at cycle %0d", expq[0].cyc);
            void'(expq.pop_front());
         end
         exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
         chk("valid_u", 32'(val_u), 32'(exp_v));
         chk("valid_s", 32'(val_s), 32'(exp_v));
         if (val_u) begin
            cap_u.push_back(pcm_u);
            cap_s.push_back(pcm_s);
         end
         if (exp_v) begin
            mon_e = expq.pop_front();
            hold_u = mon_e.u;
            hold_s = mon_e.s;
         end
         chk("pcm_u", 32'(pcm_u), 32'(hold_u));
         chk("pcm_s", 32'(pcm_s), 32'(hold_s));
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_step(input logic rn, input logic clr, input logic en, input logic b);
      resetn    = rn;
      clear     = clr;
      sample_en = en;
      bit_in    = b;
      @(posedge clk);
      #1;
      if (!rn || clr) model_clear();
      else if (en) model_accept(b);
      resetn    = 1'b1;
      clear     = 1'b0;
      sample_en = 1'b0;
   endtask

   task automatic do_reset();
      do_step(1'b0, 1'b0, 1'b0, 1'b0);
      do_step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) do_step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   typedef struct {
      int          mode;    // 0 ones, 1 zeros, 2 alternating, 3 modulator loopback
      int          nframes;
      logic [15:0] exp_u;
      logic [15:0] exp_s;
      int          tol;
   } vec_t;

   vec_t        tbl[4];
   logic [15:0] dac_sig;
   logic        rbits[512];
   logic [15:0] ref_u[$];
   logic        b;
   logic        carry;

   initial begin
      tbl[0] = '{mode: 0, nframes: 5,  exp_u: 16'hFFFF, exp_s: 16'h7FFF, tol: 0};
      tbl[1] = '{mode: 1, nframes: 5,  exp_u: 16'h0000, exp_s: 16'h8000, tol: 0};
      tbl[2] = '{mode: 2, nframes: 14, exp_u: 16'h8000, exp_s: 16'h0000, tol: 0};
      tbl[3] = '{mode: 3, nframes: 6,  exp_u: 16'hC000, exp_s: 16'h4000, tol: 8};

      do_reset();
      checking = 1'b1;
      idle(3);

      // Table-driven constant-pattern streams, sample_en every cycle
      foreach (tbl[t]) begin
         do_reset();
         cap_u.delete();
         cap_s.delete();
         dac_sig = '0;
         for (int n = 0; n < tbl[t].nframes * R; n++) begin
            case (tbl[t].mode)
               0:       b = 1'b1;
               1:       b = 1'b0;
               2:       b = (n % 2 == 0);
               default: begin
                  {carry, dac_sig} = {1'b0, dac_sig} + 17'h0C000;
                  b = carry;
               end
            endcase
            do_step(1'b1, 1'b0, 1'b1, b);
         end
         idle(4);
         chk("tbl_count", 32'(cap_u.size()), 32'(tbl[t].nframes - 2));
         foreach (cap_u[k]) begin
            chk_range("tbl_u", cap_u[k], tbl[t].exp_u, tbl[t].tol);
            chk_range("tbl_s", cap_s[k], tbl[t].exp_s, tbl[t].tol);
         end
      end

      // Gapless random run, then the same bits with sparse strobes
      for (int n = 0; n < 512; n++) rbits[n] = 1'($urandom_range(0, 1));
      do_reset();
      cap_u.delete();
      cap_s.delete();
      for (int n = 0; n < 512; n++) do_step(1'b1, 1'b0, 1'b1, rbits[n]);
      idle(4);
      ref_u = cap_u;
      chk("gapless_count", 32'(ref_u.size()), 32'd6);

      do_reset();
      cap_u.delete();
      cap_s.delete();
      for (int n = 0; n < 512; n++) begin
         idle(2 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0));
         do_step(1'b1, 1'b0, 1'b1, rbits[n]);
      end
      idle(4);
      chk("gapped_count", 32'(cap_u.size()), 32'(ref_u.size()));
      foreach (ref_u[k]) begin
         if (k < cap_u.size()) chk("gapped_seq", 32'(cap_u[k]), 32'(ref_u[k]));
      end

      // Clear together with sample_en mid-frame, then all ones
      do_reset();
      for (int n = 0; n < 100; n++) do_step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      cap_u.delete();
      cap_s.delete();
      do_step(1'b1, 1'b1, 1'b1, 1'b1);
      for (int n = 0; n < 3 * R; n++) do_step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(4);
      chk("clear_count", 32'(cap_u.size()), 32'd1);
      if (cap_u.size() > 0) chk("clear_val", 32'(cap_u[0]), 32'h0000FFFF);

      // Same sequence using reset instead of clear
      for (int n = 0; n < 100; n++) do_step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      cap_u.delete();
      cap_s.delete();
      do_step(1'b0, 1'b0, 1'b1, 1'b1);
      for (int n = 0; n < 3 * R; n++) do_step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(4);
      chk("reset_count", 32'(cap_u.size()), 32'd1);
      if (cap_u.size() > 0) chk("reset_val", 32'(cap_s[0]), 32'h00007FFF);

      // Random bits, random strobes, rare clear/reset
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 799) == 0)
            do_step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if ($urandom_range(0, 1499) == 0)
            do_step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            do_step(1'b1, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
      idle(4);
      chk("pending_outputs", 32'(expq.size()), 32'd0);

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
